// File: rtl/axi4_arbiter_if.sv
// One AXI4 port (AR/R/AW/W/B). The mst modport drives valids and payload;
// the slv modport drives readies and responses.
interface axi4_arbiter_if;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned RESP_W  = 2;

    logic               arvalid, arready;
    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;

    logic               rvalid, rready, rlast;
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;

    logic               awvalid, awready;
    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;

    logic               wvalid, wready, wlast;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;

    logic               bvalid, bready;
    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;

    modport mst (
        output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rid, rdata, rresp, rlast, output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready
    );

    modport slv (
        input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready,
        input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready
    );
endinterface

// File: rtl/axi4_arbiter.sv
// Two-master to one-slave AXI4 arbiter: one transaction in flight, round-robin
// grant, payload passes through and only handshakes/responses are gated.
module axi4_arbiter (
    input  logic        clock,
    input  logic        reset,
    axi4_arbiter_if.slv m0,
    axi4_arbiter_if.slv m1,
    axi4_arbiter_if.mst s
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   rr_q, rr_d;
    logic   addr_done_q, addr_done_d;
    logic   w_done_q, w_done_d;

    logic req0, req1, win, win_aw;
    logic in_rd, in_wr;
    logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
    logic g_arready, g_rvalid, g_awready, g_wready, g_bvalid;

    assign req0   = m0.arvalid | m0.awvalid;
    assign req1   = m1.arvalid | m1.awvalid;
    assign win    = (req0 & req1) ? rr_q : req1;
    assign win_aw = win ? m1.awvalid : m0.awvalid;
    assign in_rd  = (state_q == RD);
    assign in_wr  = (state_q == WR);

    // Handshake inputs from the granted master
    assign g_arvalid = gnt_q ? m1.arvalid : m0.arvalid;
    assign g_rready  = gnt_q ? m1.rready  : m0.rready;
    assign g_awvalid = gnt_q ? m1.awvalid : m0.awvalid;
    assign g_wvalid  = gnt_q ? m1.wvalid  : m0.wvalid;
    assign g_bready  = gnt_q ? m1.bready  : m0.bready;

    // Slave-side payload is only meaningful while its valid is high
    assign s.arid    = gnt_q ? m1.arid    : m0.arid;
    assign s.araddr  = gnt_q ? m1.araddr  : m0.araddr;
    assign s.arlen   = gnt_q ? m1.arlen   : m0.arlen;
    assign s.arsize  = gnt_q ? m1.arsize  : m0.arsize;
    assign s.arburst = gnt_q ? m1.arburst : m0.arburst;
    assign s.awid    = gnt_q ? m1.awid    : m0.awid;
    assign s.awaddr  = gnt_q ? m1.awaddr  : m0.awaddr;
    assign s.awlen   = gnt_q ? m1.awlen   : m0.awlen;
    assign s.awsize  = gnt_q ? m1.awsize  : m0.awsize;
    assign s.awburst = gnt_q ? m1.awburst : m0.awburst;
    assign s.wdata   = gnt_q ? m1.wdata   : m0.wdata;
    assign s.wstrb   = gnt_q ? m1.wstrb   : m0.wstrb;
    assign s.wlast   = gnt_q ? m1.wlast   : m0.wlast;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        addr_done_d = addr_done_q;
        w_done_d    = w_done_q;
        s.arvalid   = 1'b0;
        s.rready    = 1'b0;
        s.awvalid   = 1'b0;
        s.wvalid    = 1'b0;
        s.bready    = 1'b0;
        g_arready   = 1'b0;
        g_rvalid    = 1'b0;
        g_awready   = 1'b0;
        g_wready    = 1'b0;
        g_bvalid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d     = win_aw ? WR : RD;
                    gnt_d       = win;
                    addr_done_d = 1'b0;
                    w_done_d    = 1'b0;
                end
            end
            RD: begin
                s.arvalid = g_arvalid & ~addr_done_q;
                g_arready = s.arready & ~addr_done_q;
                if (g_arvalid & s.arready & ~addr_done_q) addr_done_d = 1'b1;
                g_rvalid = s.rvalid;
                s.rready = g_rready;
                if (s.rvalid & g_rready & s.rlast) begin
                    state_d = IDLE;
                    rr_d    = ~gnt_q;
                end
            end
            WR: begin
                s.awvalid = g_awvalid & ~addr_done_q;
                g_awready = s.awready & ~addr_done_q;
                if (g_awvalid & s.awready & ~addr_done_q) addr_done_d = 1'b1;
                // W may complete before or after AW; wlast closes the data phase
                s.wvalid = g_wvalid & ~w_done_q;
                g_wready = s.wready & ~w_done_q;
                if (g_wvalid & s.wready & s.wlast & ~w_done_q) w_done_d = 1'b1;
                g_bvalid = s.bvalid;
                s.bready = g_bready;
                if (s.bvalid & g_bready) begin
                    state_d = IDLE;
                    rr_d    = ~gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fan granted-side handshakes and responses back to the owning master
    assign m0.arready = g_arready & ~gnt_q;
    assign m1.arready = g_arready &  gnt_q;
    assign m0.rvalid  = g_rvalid  & ~gnt_q;
    assign m1.rvalid  = g_rvalid  &  gnt_q;
    assign m0.awready = g_awready & ~gnt_q;
    assign m1.awready = g_awready &  gnt_q;
    assign m0.wready  = g_wready  & ~gnt_q;
    assign m1.wready  = g_wready  &  gnt_q;
    assign m0.bvalid  = g_bvalid  & ~gnt_q;
    assign m1.bvalid  = g_bvalid  &  gnt_q;

    assign m0.rid   = (in_rd & ~gnt_q) ? s.rid   : '0;
    assign m0.rdata = (in_rd & ~gnt_q) ? s.rdata : '0;
    assign m0.rresp = (in_rd & ~gnt_q) ? s.rresp : '0;
    assign m0.rlast = in_rd & ~gnt_q & s.rlast;
    assign m1.rid   = (in_rd &  gnt_q) ? s.rid   : '0;
    assign m1.rdata = (in_rd &  gnt_q) ? s.rdata : '0;
    assign m1.rresp = (in_rd &  gnt_q) ? s.rresp : '0;
    assign m1.rlast = in_rd & gnt_q & s.rlast;
    assign m0.bid   = (in_wr & ~gnt_q) ? s.bid   : '0;
    assign m0.bresp = (in_wr & ~gnt_q) ? s.bresp : '0;
    assign m1.bid   = (in_wr &  gnt_q) ? s.bid   : '0;
    assign m1.bresp = (in_wr &  gnt_q) ? s.bresp : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            rr_q        <= 1'b0;
            addr_done_q <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            addr_done_q <= addr_done_d;
            w_done_q    <= w_done_d;
        end
    end
endmodule

// File: tb/tb_axi4_arbiter.sv
// Directed bench for axi4_arbiter: arbitration vector table plus hand-written
// burst, write, alternation, reset-abort and slave-stall sequences.
module tb_axi4_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    axi4_arbiter_if m0_if ();
    axi4_arbiter_if m1_if ();
    axi4_arbiter_if s_if ();

    axi4_arbiter dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       m0_ar, m0_aw, m1_ar, m1_aw;
        logic       exp_arv, exp_awv;
        logic [3:0] exp_id;
        logic       exp_m0_rdy, exp_m1_rdy;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        m0_if.arvalid = 0; m0_if.arid = 0; m0_if.araddr = 0; m0_if.arlen = 0;
        m0_if.arsize = 0; m0_if.arburst = 0; m0_if.rready = 0;
        m0_if.awvalid = 0; m0_if.awid = 0; m0_if.awaddr = 0; m0_if.awlen = 0;
        m0_if.awsize = 0; m0_if.awburst = 0; m0_if.wvalid = 0; m0_if.wdata = 0;
        m0_if.wstrb = 0; m0_if.wlast = 0; m0_if.bready = 0;
        m1_if.arvalid = 0; m1_if.arid = 0; m1_if.araddr = 0; m1_if.arlen = 0;
        m1_if.arsize = 0; m1_if.arburst = 0; m1_if.rready = 0;
        m1_if.awvalid = 0; m1_if.awid = 0; m1_if.awaddr = 0; m1_if.awlen = 0;
        m1_if.awsize = 0; m1_if.awburst = 0; m1_if.wvalid = 0; m1_if.wdata = 0;
        m1_if.wstrb = 0; m1_if.wlast = 0; m1_if.bready = 0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rid = 0; s_if.rdata = 0;
        s_if.rresp = 0; s_if.rlast = 0; s_if.awready = 0; s_if.wready = 0;
        s_if.bvalid = 0; s_if.bid = 0; s_if.bresp = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] all_hs();
        return {m0_if.arready, m0_if.rvalid, m0_if.awready, m0_if.wready, m0_if.bvalid,
                m1_if.arready, m1_if.rvalid, m1_if.awready, m1_if.wready, m1_if.bvalid,
                s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready, 1'b0};
    endfunction

    initial begin
        logic [3:0] act_id;
        int n;
        clr();

        // {m0_ar, m0_aw, m1_ar, m1_aw, arv, awv, id, m0_rdy, m1_rdy}; rr=0 after reset
        vecs[0] = '{1, 0, 0, 0, 1, 0, 4'd1, 1, 0};
        vecs[1] = '{0, 0, 1, 0, 1, 0, 4'd2, 0, 1};
        vecs[2] = '{1, 0, 1, 0, 1, 0, 4'd1, 1, 0};
        vecs[3] = '{0, 0, 1, 1, 0, 1, 4'd6, 0, 1};
        vecs[4] = '{0, 1, 1, 0, 0, 1, 4'd5, 1, 0};
        vecs[5] = '{1, 1, 0, 1, 0, 1, 4'd5, 1, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 4'd0, 0, 0};

        do_reset();
        #1 chk("reset_outputs", 32'(all_hs()), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            m0_if.arid = 4'd1; m0_if.awid = 4'd5; m1_if.arid = 4'd2; m1_if.awid = 4'd6;
            m0_if.arvalid = vecs[i].m0_ar; m0_if.awvalid = vecs[i].m0_aw;
            m1_if.arvalid = vecs[i].m1_ar; m1_if.awvalid = vecs[i].m1_aw;
            s_if.arready = 1'b1; s_if.awready = 1'b1;
            #1 chk($sformatf("v%0d_no_comb", i), 32'({s_if.arvalid, s_if.awvalid}), 32'd0);
            @(negedge clock); #1;
            chk($sformatf("v%0d_valids", i), 32'({s_if.arvalid, s_if.awvalid}),
                32'({vecs[i].exp_arv, vecs[i].exp_awv}));
            act_id = s_if.awvalid ? s_if.awid : (s_if.arvalid ? s_if.arid : 4'd0);
            chk($sformatf("v%0d_id", i), 32'(act_id), 32'(vecs[i].exp_id));
            chk($sformatf("v%0d_readies", i),
                32'({m0_if.arready | m0_if.awready, m1_if.arready | m1_if.awready}),
                32'({vecs[i].exp_m0_rdy, vecs[i].exp_m1_rdy}));
        end

        // m0 4-beat read
        do_reset();
        @(negedge clock);
        m0_if.arvalid = 1; m0_if.arid = 4'd1; m0_if.araddr = 32'h3000_0000; m0_if.arlen = 8'd3;
        #1 chk("rd_ar_same_cycle", 32'(s_if.arvalid), 32'd0);
        @(negedge clock); #1;
        chk("rd_ar_next_cycle", 32'(s_if.arvalid), 32'd1);
        chk("rd_araddr", s_if.araddr, 32'h3000_0000);
        chk("rd_arlen", 32'(s_if.arlen), 32'd3);
        s_if.arready = 1;
        #1 chk("rd_m0_arready", 32'(m0_if.arready), 32'd1);
        @(negedge clock);
        m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 1;
        for (int b = 0; b < 4; b++) begin
            s_if.rvalid = 1; s_if.rid = 4'd1; s_if.rdata = 32'(8'h11 * (b + 1));
            s_if.rlast = (b == 3);
            #1;
            chk($sformatf("rd_beat%0d_data", b), m0_if.rdata, 32'(8'h11 * (b + 1)));
            chk($sformatf("rd_beat%0d_valids", b), 32'({m0_if.rvalid, m1_if.rvalid}), 32'b10);
            @(negedge clock);
        end
        s_if.rvalid = 0; s_if.rlast = 0;
        #1 chk("rd_idle_after_rlast", 32'({s_if.rready, m0_if.rlast}), 32'd0);

        // both masters AR together: m0 first, m1 one idle cycle after completion
        do_reset();
        m0_if.arvalid = 1; m0_if.arid = 4'd1; m1_if.arvalid = 1; m1_if.arid = 4'd2;
        s_if.arready = 1; m0_if.rready = 1; m1_if.rready = 1;
        @(negedge clock); #1;
        chk("rr_first_id", 32'(s_if.arid), 32'd1);
        chk("rr_first_ready", 32'({m0_if.arready, m1_if.arready}), 32'b10);
        @(negedge clock);
        m0_if.arvalid = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 4'd1;
        #1 chk("rr_first_route", 32'({m0_if.rvalid, m1_if.rvalid}), 32'b10);
        @(negedge clock);
        s_if.rvalid = 0; s_if.rlast = 0;
        #1 chk("rr_gap_idle", 32'(s_if.arvalid), 32'd0);
        @(negedge clock); #1;
        chk("rr_second_ar", 32'({s_if.arvalid, s_if.arid}), 32'({1'b1, 4'd2}));
        @(negedge clock);
        m1_if.arvalid = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 4'd2;
        #1 chk("rr_second_rid", 32'({m1_if.rvalid, m1_if.rid, m0_if.rvalid, m0_if.rid}),
               32'({1'b1, 4'd2, 1'b0, 4'd0}));
        @(negedge clock);
        s_if.rvalid = 0; s_if.rlast = 0;

        // m1 write (W before AW) beats its own read
        do_reset();
        m1_if.awvalid = 1; m1_if.awid = 4'd3; m1_if.awaddr = 32'h8000_0010;
        m1_if.arvalid = 1; m1_if.arid = 4'd4;
        m1_if.wvalid = 1; m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wlast = 1;
        s_if.wready = 1;
        #1 chk("wr_no_comb", 32'(s_if.awvalid), 32'd0);
        @(negedge clock); #1;
        chk("wr_first", 32'({s_if.awvalid, s_if.arvalid, s_if.wvalid}), 32'b101);
        chk("wr_awaddr", s_if.awaddr, 32'h8000_0010);
        chk("wr_wdata", s_if.wdata, 32'hDEAD_BEEF);
        chk("wr_wready", 32'({m1_if.wready, m0_if.wready, s_if.wstrb}), 32'({2'b10, 4'hF}));
        @(negedge clock); #1;
        chk("wr_w_done_gate", 32'({s_if.wvalid, m1_if.wready}), 32'd0);
        m1_if.wvalid = 0; s_if.awready = 1;
        #1 chk("wr_awready", 32'(m1_if.awready), 32'd1);
        @(negedge clock);
        m1_if.awvalid = 0; s_if.awready = 0; s_if.wready = 0;
        s_if.bvalid = 1; s_if.bid = 4'd3; s_if.bresp = 2'd0; m1_if.bready = 1;
        #1 chk("wr_b_route", 32'({m1_if.bvalid, m1_if.bid, m1_if.bresp, m0_if.bvalid, s_if.bready}),
               32'({1'b1, 4'd3, 2'd0, 1'b0, 1'b1}));
        @(negedge clock);
        s_if.bvalid = 0;
        #1 chk("wr_idle_gap", 32'(s_if.arvalid), 32'd0);
        @(negedge clock); #1;
        chk("wr_then_read", 32'({s_if.arvalid, s_if.arid}), 32'({1'b1, 4'd4}));
        s_if.arready = 1;
        @(negedge clock);
        m1_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 4'd4; m1_if.rready = 1;
        #1 chk("wr_read_rid", 32'(m1_if.rid), 32'd4);
        @(negedge clock);
        s_if.rvalid = 0; s_if.rlast = 0;

        // continuous contention: grants alternate
        do_reset();
        m0_if.arvalid = 1; m0_if.arid = 4'd1; m1_if.arvalid = 1; m1_if.arid = 4'd2;
        m0_if.rready = 1; m1_if.rready = 1;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            @(negedge clock); #1;
            while (!s_if.arvalid && n < 5) begin
                @(negedge clock); #1;
                n++;
            end
            chk($sformatf("alt%0d_grant_wait", t), 32'(n < 5), 32'd1);
            chk($sformatf("alt%0d_id", t), 32'(s_if.arid), (t % 2 == 0) ? 32'd1 : 32'd2);
            act_id = s_if.arid;
            s_if.arready = 1;
            @(negedge clock);
            s_if.arready = 0;
            s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = act_id; s_if.rdata = 32'(t);
            #1 chk($sformatf("alt%0d_route", t), 32'({m0_if.rvalid, m1_if.rvalid}),
                   (act_id == 4'd1) ? 32'b10 : 32'b01);
            @(negedge clock);
            s_if.rvalid = 0; s_if.rlast = 0;
        end
        m0_if.arvalid = 0; m1_if.arvalid = 0;

        // reset during beat 2 of an 8-beat burst
        do_reset();
        m0_if.arvalid = 1; m0_if.arid = 4'd1; m0_if.arlen = 8'd7; s_if.arready = 1;
        m0_if.rready = 1;
        @(negedge clock);
        @(negedge clock);
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rid = 4'd1; s_if.rdata = 32'h1;
        @(negedge clock);
        s_if.rdata = 32'h2;
        #1 chk("abort_beat2_live", 32'(m0_if.rvalid), 32'd1);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("abort_outputs_zero", 32'(all_hs()), 32'd0);
        chk("abort_rdata_zero", m0_if.rdata, 32'd0);
        reset = 1'b0;
        clr();
        m1_if.awvalid = 1; m1_if.awid = 4'd7;
        @(negedge clock); #1;
        chk("abort_fresh_grant", 32'({s_if.awvalid, s_if.awid}), 32'({1'b1, 4'd7}));

        // slave stalls arready for 10 cycles: grant holds on m0
        do_reset();
        m0_if.arvalid = 1; m0_if.arid = 4'd1; m1_if.arvalid = 1; m1_if.arid = 4'd2;
        m0_if.rready = 1; m1_if.rready = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock); #1;
            chk($sformatf("stall%0d", c),
                32'({m0_if.arready, m1_if.arready, s_if.arvalid, s_if.arid}),
                32'({2'b00, 1'b1, 4'd1}));
        end
        s_if.arready = 1;
        @(negedge clock);
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 4'd1;
        @(negedge clock);
        s_if.rvalid = 0; s_if.rlast = 0;
        @(negedge clock); #1;
        chk("stall_then_m1", 32'({s_if.arvalid, s_if.arid}), 32'({1'b1, 4'd2}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
